multiplier_appr: RTL and testbench
==================================

// Module: multiplier_appr
// PURPOSE
//  Signed N x N approximate multiplier for error-tolerant datapaths (DSP/NN MAC).
//  - Saves area/power by dropping low-weight partial-product bits (fixed-width
//    column truncation) of the magnitude product.
//  - Two-stage pipeline with a valid strobe; sits between operand registers and
//    an accumulator.
// PARAMETERS
//  N       16  operand width (signed two's complement), N >= 4
//  TRUNC    8  partial-product columns dropped: bits of weight < 2^TRUNC discarded;
//              0 = exact multiplier; legal 0..2N-1
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     a/b valid this cycle
//  a          in   N     signed multiplicand
//  b          in   N     signed multiplier
//  out_valid  out  1     out holds result of operands sampled 2 cycles earlier
//  out        out  2N    signed approximate product
// BEHAVIOUR
//  - Reset: rst high forces out=0, out_valid=0 and clears all pipeline
//    registers immediately (asynchronous). Effective mid-operation: in-flight
//    results are discarded. First capture occurs on the first rising edge
//    after rst is released.
//  - Stage 1 (edge 1): register a, b, in_valid.
//  - Stage 2 (edge 2): register out and out_valid.
//  - Latency: exactly 2 cycles; one result per cycle, no stalls.
//  - out_valid mirrors in_valid delayed by 2.
//  - out updates every cycle regardless of valid (garbage when out_valid=0).
//  - Arithmetic:
//      - sign = a[N-1] ^ b[N-1]
//      - magnitudes |a|, |b| as N-bit unsigned; -2^(N-1) maps to 2^(N-1),
//        no overflow
//      - pp_i = |b|[i] ? (|a| << i) : 0, for i = 0..N-1, each 2N bits wide
//      - mask every pp bit at position < TRUNC to 0; sum the masked pps
//        (adder tree, any structure) -> P
//      - out = sign ? -P : P (2N-bit two's complement)
//      - result 0 is always +0, never negative zero
//  - Error: approximate product magnitude never exceeds the exact magnitude.
//    TRUNC=0 yields the bit-exact a*b.
//  - Corners:
//      - a = b = -2^(N-1) gives +2^(2N-2); fits in 2N bits, no wrap
//      - any zero operand gives 0
// TESTING (N=16, TRUNC=8 unless noted)
//  - rst=1 with inputs toggling -> out=0, out_valid=0.
//    Release rst, a=3, b=5, in_valid=1 -> 2 cycles later out=0
//    (all pp bits below 2^8), out_valid=1.
//  - a=256, b=256 -> out=65536.
//    a=-256, b=300 -> out=-76800 (exact, no bits dropped).
//  - a=255, b=255 -> out=63232 (exact 65025; truncation error 1793).
//  - a=-32768, b=-32768 -> out=1073741824.
//    a=-32768, b=0 -> out=0.
//  - Back-to-back: vectors on 3 consecutive cycles -> results on 3 consecutive
//    cycles, each 2 cycles late.
//    in_valid pattern 1,0,1 -> out_valid pattern 1,0,1.
//  - Reset asserted mid-stream -> out/out_valid clear immediately, with no
//    clock edge needed.
//    TRUNC=0 random sweep -> out equals a*b exactly.

Source files
------------

// File: rtl/multiplier_appr.sv
// Signed N x N approximate multiplier: sign-magnitude partial products with the
// low TRUNC columns dropped, two-stage pipeline with a valid strobe.
module multiplier_appr #(
   parameter int N     = 16,
   parameter int TRUNC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   output logic             out_valid,
   output logic [2*N-1:0]   out
);

   // Columns of weight below 2^TRUNC never reach the adder tree.
   localparam logic [2*N-1:0] KEEP_MASK = {(2*N){1'b1}} << TRUNC;

   // -2^(N-1) maps onto 2^(N-1), which still fits as an N-bit unsigned value.
   function automatic logic [N-1:0] mag_f(input logic [N-1:0] x);
      logic [N-1:0] m;
      if (x[N-1]) begin
         m = ~x + {{(N-1){1'b0}}, 1'b1};
      end else begin
         m = x;
      end
      return m;
   endfunction

   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic           v1_q;
   logic           v2_q;
   logic [2*N-1:0] out_q;
   logic [2*N-1:0] out_d;

   logic [N-1:0]   mag_a_s;
   logic [N-1:0]   mag_b_s;
   logic [2*N-1:0] pp_s;
   logic [2*N-1:0] prod_s;
   logic           sign_s;

   // Masked partial-product sum of the stage-1 operands, then sign restore.
   always_comb begin
      mag_a_s = mag_f(a_q);
      mag_b_s = mag_f(b_q);
      sign_s  = a_q[N-1] ^ b_q[N-1];
      prod_s  = '0;
      pp_s    = '0;
      for (int i = 0; i < N; i++) begin
         pp_s   = mag_b_s[i] ? (({{N{1'b0}}, mag_a_s} << i) & KEEP_MASK) : '0;
         prod_s = prod_s + pp_s;
      end
      // A zero magnitude stays +0 regardless of operand signs.
      if (sign_s && (prod_s != '0)) begin
         out_d = '0 - prod_s;
      end else begin
         out_d = prod_s;
      end
   end

   // Operand stage and result stage; reset discards everything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         out_q <= '0;
      end else begin
         a_q   <= a;
         b_q   <= b;
         v1_q  <= in_valid;
         v2_q  <= v1_q;
         out_q <= out_d;
      end
   end

   assign out_valid = v2_q;
   assign out       = out_q;

endmodule

// File: tb/tb_multiplier_appr.sv
// Bench for multiplier_appr: column-weight reference model plus directed literal checks.
module tb_multiplier_appr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] a = 16'd0;
   logic [15:0] b = 16'd0;
   logic        vld8, vld0;
   logic [31:0] out8, out0;

   int total = 0;
   int bad   = 0;
   logic check_en = 1'b0;

   always #5 clk = ~clk;

   multiplier_appr #(.N(16), .TRUNC(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(vld8), .out(out8));

   multiplier_appr #(.N(16), .TRUNC(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(vld0), .out(out0));

   // Reference: sum of single-bit products |a|[i]&|b|[j] over columns i+j >= tr.
   function automatic longint model(input logic [15:0] x, input logic [15:0] y, input int tr);
      longint mx, my, p;
      logic neg;
      mx = $signed(x);
      my = $signed(y);
      neg = (mx < 0) != (my < 0);
      if (mx < 0) mx = -mx;
      if (my < 0) my = -my;
      p = 0;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            if (mx[i] && my[j] && (i + j >= tr)) p = p + (longint'(1) << (i + j));
      return neg ? -p : p;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Expected-output pipeline: the result seen after edge k+2 belongs to inputs at edge k.
   logic [15:0] m_a1, m_b1;
   logic        m_v1, m_v2;
   longint      m_out8, m_out0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_a1 <= 16'd0; m_b1 <= 16'd0; m_v1 <= 1'b0; m_v2 <= 1'b0;
         m_out8 <= 0; m_out0 <= 0;
      end else begin
         m_a1   <= a;
         m_b1   <= b;
         m_v1   <= in_valid;
         m_v2   <= m_v1;
         m_out8 <= model(m_a1, m_b1, 8);
         m_out0 <= model(m_a1, m_b1, 0);
      end
   end

   // Per-cycle comparison against the model on the falling edge.
   always @(negedge clk) begin
      if (check_en && !rst) begin
         chk("valid_t8", longint'(vld8), longint'(m_v2));
         chk("valid_t0", longint'(vld0), longint'(m_v2));
         if (m_v2) begin
            chk("out_t8", longint'($signed(out8)), m_out8);
            chk("out_t0", longint'($signed(out0)), m_out0);
         end
      end
   end

   task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic v);
      @(negedge clk);
      a = x; b = y; in_valid = v;
   endtask

   task automatic lit(input string name, input logic [15:0] x, input logic [15:0] y, input longint exp8);
      drive(x, y, 1'b1);
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk(name, longint'($signed(out8)), exp8);
      chk({name, "_exact"}, longint'($signed(out0)), longint'($signed(x)) * longint'($signed(y)));
   endtask

   initial begin
      // Model pinned to hand-computed values.
      chk("model_255", model(16'd255, 16'd255, 8), 63232);
      chk("model_3x5", model(16'd3, 16'd5, 8), 0);
      chk("model_neg", model(-16'sd256, 16'd300, 8), -76800);

      // Reset held with toggling inputs.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         a = 16'(k * 77 + 1000); b = 16'(k * 33 + 500); in_valid = k[0];
         @(posedge clk); #1;
         chk("rst_out", longint'(out8), 0);
         chk("rst_valid", longint'(vld8), 0);
      end

      @(negedge clk);
      rst = 1'b0; a = 16'd3; b = 16'd5; in_valid = 1'b1;
      check_en = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("first_out", longint'($signed(out8)), 0);
      chk("first_exact", longint'($signed(out0)), 15);
      chk("first_valid", longint'(vld8), 1);

      lit("256x256", 16'd256, 16'd256, 65536);
      lit("m256x300", -16'sd256, 16'd300, -76800);
      lit("255x255", 16'd255, 16'd255, 63232);
      lit("min_x_min", 16'h8000, 16'h8000, 1073741824);
      lit("min_x_0", 16'h8000, 16'd0, 0);
      lit("neg_x_0", -16'sd5, 16'd0, 0);

      // Valid pattern 1,0,1 on consecutive cycles.
      drive(16'd1000, 16'd2000, 1'b1);
      drive(16'd1234, 16'd4321, 1'b0);
      drive(-16'sd3000, 16'd700, 1'b1);
      chk("pat_v0", longint'(vld8), 1);
      chk("pat_out0", longint'($signed(out8)), model(16'd1000, 16'd2000, 8));
      drive(16'd0, 16'd0, 1'b0);
      chk("pat_v1", longint'(vld8), 0);
      @(negedge clk);
      chk("pat_v2", longint'(vld8), 1);
      chk("pat_out2", longint'($signed(out8)), model(-16'sd3000, 16'd700, 8));

      // Back-to-back stream including corners, checked every cycle by the model.
      drive(16'h7fff, 16'h7fff, 1'b1);
      drive(16'h8000, 16'h7fff, 1'b1);
      drive(16'hffff, 16'hffff, 1'b1);
      drive(16'h8000, 16'hffff, 1'b1);
      drive(16'd511, -16'sd511, 1'b1);

      // Asynchronous reset while results are in flight.
      @(negedge clk);
      chk("pre_rst_valid", longint'(vld8), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_out", longint'(out8), 0);
      chk("async_out0", longint'(out0), 0);
      chk("async_valid", longint'(vld8), 0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_valid", longint'(vld8), 0);

      // Random sweep: TRUNC=0 instance must match a*b, TRUNC=8 the model.
      for (int k = 0; k < 300; k++) begin
         drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      drive(16'd0, 16'd0, 1'b0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
